// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer: M-stage store requests, the drain
// handshake to data memory, and the load-address hazard probe.
interface store_write_buffer_if;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        st_misalign;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic        ld_check_valid;
   logic [31:0] ld_check_addr;
   logic        ld_conflict;
   logic        empty;

   modport slave (
      input  st_valid, st_op, st_addr, st_data, mem_ack, ld_check_valid, ld_check_addr,
      output st_ready, st_misalign, mem_req, mem_addr, mem_byteen, mem_wdata,
             ld_conflict, empty
   );

   modport master (
      output st_valid, st_op, st_addr, st_data, mem_ack, ld_check_valid, ld_check_addr,
      input  st_ready, st_misalign, mem_req, mem_addr, mem_byteen, mem_wdata,
             ld_conflict, empty
   );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: encodes sw/sh/sb into byte enables and lane-aligned data,
// queues legal stores in a FIFO drained over req/ack, and flags load hazards.
module store_write_buffer #(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   store_write_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [DEPTH-1:0] e_valid;
   logic [29:0]      e_addr [DEPTH];
   logic [3:0]       e_be   [DEPTH];
   logic [31:0]      e_data [DEPTH];

   logic [3:0]  enc_be;
   logic [31:0] enc_data;
   logic        enc_bad;
   logic        not_empty;
   logic        push;
   logic        pop;
   logic        hit;
   logic        unused_ld_bits;

   always_comb begin
      enc_be   = 4'b0000;
      enc_data = 32'h0;
      enc_bad  = 1'b0;
      case (bus.st_op)
         2'b00: begin
            enc_be   = 4'b1111;
            enc_data = bus.st_data;
            enc_bad  = (bus.st_addr[1:0] != 2'b00);
         end
         2'b01: begin
            enc_be   = 4'b0001 << bus.st_addr[1:0];
            enc_data = {4{bus.st_data[7:0]}};
         end
         2'b10: begin
            enc_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            enc_data = {2{bus.st_data[15:0]}};
            enc_bad  = bus.st_addr[0];
         end
         default: enc_bad = 1'b1;
      endcase
   end

   assign not_empty       = (count != '0);
   assign bus.st_misalign = bus.st_valid & enc_bad;
   assign bus.st_ready    = (count < DEPTH_C);
   assign bus.empty       = ~not_empty;
   assign bus.mem_req     = not_empty;

   // Full blocks pushes even when the head is popping this same cycle.
   assign push = bus.st_valid & bus.st_ready & ~enc_bad;
   assign pop  = not_empty & bus.mem_ack;

   assign bus.mem_addr   = not_empty ? {e_addr[head], 2'b00} : 32'h0;
   assign bus.mem_byteen = not_empty ? e_be[head] : 4'b0000;
   assign bus.mem_wdata  = not_empty ? e_data[head] : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         e_valid <= '0;
      end else begin
         if (push) begin
            tail          <= tail + 1'b1;
            e_valid[tail] <= 1'b1;
         end
         if (pop) begin
            head          <= head + 1'b1;
            e_valid[head] <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset; it is only visible through valid/count.
   always_ff @(posedge clk) begin
      if (push) begin
         e_addr[tail] <= bus.st_addr[31:2];
         e_be[tail]   <= enc_be;
         e_data[tail] <= enc_data;
      end
   end

   // Word-granular compare against buffered entries only, byte enables ignored.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (e_valid[i] && (e_addr[i] == bus.ld_check_addr[31:2]))
            hit = 1'b1;
      end
   end

   assign bus.ld_conflict = bus.ld_check_valid & hit;
   assign unused_ld_bits  = ^bus.ld_check_addr[1:0];
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer with DEPTH = 2.
module tb_store_write_buffer;
   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   store_write_buffer_if bus ();

   store_write_buffer #(.DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.st_valid       = 1'b0;
      bus.st_op          = 2'b00;
      bus.st_addr        = 32'h0;
      bus.st_data        = 32'h0;
      bus.mem_ack        = 1'b0;
      bus.ld_check_valid = 1'b0;
      bus.ld_check_addr  = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      bus.ld_check_valid = 1'b1;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", bus.mem_req); else pass_cnt++;
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL rst_empty got %b want 1", bus.empty); else pass_cnt++;
      total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL rst_st_ready got %b want 1", bus.st_ready); else pass_cnt++;
      total_cnt++; if (bus.ld_conflict !== 1'b0) $display("FAIL rst_ld_conflict got %b want 0", bus.ld_conflict); else pass_cnt++;
      total_cnt++; if ({bus.mem_addr, bus.mem_byteen, bus.mem_wdata} !== 68'h0) $display("FAIL rst_mem_bus got %h/%b/%h want 0", bus.mem_addr, bus.mem_byteen, bus.mem_wdata); else pass_cnt++;
      bus.ld_check_valid = 1'b0;
      reset = 1'b0;
      step();
   endtask

   task automatic test_sb();
      bus.st_valid = 1'b1; bus.st_op = 2'b01; bus.st_addr = 32'h0000_1003; bus.st_data = 32'h0000_00A5;
      #1;
      total_cnt++; if (bus.st_misalign !== 1'b0) $display("FAIL sb_misalign got %b want 0", bus.st_misalign); else pass_cnt++;
      total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL sb_no_bypass got %b want 0", bus.mem_req); else pass_cnt++;
      step();
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL sb_mem_req got %b want 1", bus.mem_req); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 32'h0000_1000) $display("FAIL sb_mem_addr got %h want 00001000", bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.mem_byteen !== 4'b1000) $display("FAIL sb_byteen got %b want 1000", bus.mem_byteen); else pass_cnt++;
      total_cnt++; if (bus.mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata got %h want a5a5a5a5", bus.mem_wdata); else pass_cnt++;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sb_drained got %b want 1", bus.empty); else pass_cnt++;
   endtask

   task automatic test_sh_and_illegal();
      bus.st_valid = 1'b1; bus.st_op = 2'b10; bus.st_addr = 32'h0000_2002; bus.st_data = 32'h1234_BEEF;
      step();
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.mem_byteen !== 4'b1100) $display("FAIL sh_hi_byteen got %b want 1100", bus.mem_byteen); else pass_cnt++;
      total_cnt++; if (bus.mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_hi_wdata got %h want beefbeef", bus.mem_wdata); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 32'h0000_2000) $display("FAIL sh_hi_addr got %h want 00002000", bus.mem_addr); else pass_cnt++;
      bus.mem_ack = 1'b1;
      // lower-half store pushed while the upper one pops
      bus.st_valid = 1'b1; bus.st_op = 2'b10; bus.st_addr = 32'h0000_2000; bus.st_data = 32'h0000_5A5A;
      step();
      bus.st_valid = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.mem_byteen !== 4'b0011) $display("FAIL sh_lo_byteen got %b want 0011", bus.mem_byteen); else pass_cnt++;
      total_cnt++; if (bus.mem_wdata !== 32'h5A5A_5A5A) $display("FAIL sh_lo_wdata got %h want 5a5a5a5a", bus.mem_wdata); else pass_cnt++;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      bus.st_valid = 1'b1; bus.st_op = 2'b10; bus.st_addr = 32'h0000_2001;
      #1;
      total_cnt++; if (bus.st_misalign !== 1'b1) $display("FAIL sh_odd_misalign got %b want 1", bus.st_misalign); else pass_cnt++;
      step();
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sh_odd_dropped got %b want 1", bus.empty); else pass_cnt++;
      bus.st_op = 2'b11; bus.st_addr = 32'h0000_2000;
      #1;
      total_cnt++; if (bus.st_misalign !== 1'b1) $display("FAIL op11_misalign got %b want 1", bus.st_misalign); else pass_cnt++;
      step();
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL op11_dropped got %b want 1", bus.empty); else pass_cnt++;
      bus.st_op = 2'b00; bus.st_addr = 32'h0000_4002;
      #1;
      total_cnt++; if (bus.st_misalign !== 1'b1) $display("FAIL sw_mis_misalign got %b want 1", bus.st_misalign); else pass_cnt++;
      step();
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sw_mis_dropped got %b want 1", bus.empty); else pass_cnt++;
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.st_misalign !== 1'b0) $display("FAIL misalign_needs_valid got %b want 0", bus.st_misalign); else pass_cnt++;
   endtask

   task automatic test_full();
      bus.mem_ack = 1'b0;
      bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h10; bus.st_data = 32'h1111_1111;
      step();
      bus.st_addr = 32'h14; bus.st_data = 32'h2222_2222;
      step();
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.st_ready !== 1'b0) $display("FAIL full_st_ready got %b want 0", bus.st_ready); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 32'h10) $display("FAIL full_head0 got %h want 00000010", bus.mem_addr); else pass_cnt++;
      bus.st_valid = 1'b1; bus.st_addr = 32'h18; bus.st_data = 32'h3333_3333;
      bus.mem_ack = 1'b1;
      #1;
      total_cnt++; if (bus.st_ready !== 1'b0) $display("FAIL full_pop_ready got %b want 0", bus.st_ready); else pass_cnt++;
      step();
      bus.st_valid = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL full_ready_back got %b want 1", bus.st_ready); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== 32'h14) $display("FAIL full_head1 got %h want 00000014", bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.mem_wdata !== 32'h2222_2222) $display("FAIL full_head1_data got %h want 22222222", bus.mem_wdata); else pass_cnt++;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL full_third_dropped got %b want 1", bus.empty); else pass_cnt++;
   endtask

   task automatic test_ld_conflict();
      bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h3000; bus.st_data = 32'hCAFE_0000;
      bus.ld_check_valid = 1'b1; bus.ld_check_addr = 32'h3000;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b0) $display("FAIL ld_same_cycle_push got %b want 0", bus.ld_conflict); else pass_cnt++;
      step();
      bus.st_valid = 1'b0;
      bus.ld_check_addr = 32'h3002;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b1) $display("FAIL ld_hit got %b want 1", bus.ld_conflict); else pass_cnt++;
      bus.ld_check_addr = 32'h3004;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b0) $display("FAIL ld_other_word got %b want 0", bus.ld_conflict); else pass_cnt++;
      bus.ld_check_addr = 32'h3000; bus.ld_check_valid = 1'b0;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b0) $display("FAIL ld_not_valid got %b want 0", bus.ld_conflict); else pass_cnt++;
      bus.ld_check_valid = 1'b1; bus.mem_ack = 1'b1;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b1) $display("FAIL ld_hit_while_pop got %b want 1", bus.ld_conflict); else pass_cnt++;
      step();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.ld_conflict !== 1'b0) $display("FAIL ld_after_pop got %b want 0", bus.ld_conflict); else pass_cnt++;
      bus.ld_check_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h100; bus.st_data = 32'hD0;
      step();
      for (int k = 0; k < 6; k++) begin
         bus.st_addr = 32'h100 + 32'(4 * (k + 1));
         bus.st_data = 32'hD0 + 32'(k + 1);
         bus.mem_ack = 1'b1;
         #1;
         total_cnt++; if (bus.mem_addr !== 32'h100 + 32'(4 * k) || bus.mem_wdata !== 32'hD0 + 32'(k)) $display("FAIL b2b_head_%0d got %h/%h want %h/%h", k, bus.mem_addr, bus.mem_wdata, 32'h100 + 32'(4 * k), 32'hD0 + 32'(k)); else pass_cnt++;
         total_cnt++; if (bus.mem_req !== 1'b1 || bus.st_ready !== 1'b1) $display("FAIL b2b_count1_%0d got req=%b rdy=%b want 1/1", k, bus.mem_req, bus.st_ready); else pass_cnt++;
         step();
      end
      bus.st_valid = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.mem_addr !== 32'h118 || bus.mem_wdata !== 32'hD6) $display("FAIL b2b_last got %h/%h want 00000118/000000d6", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL b2b_no_dup got %b want 1", bus.empty); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h200; bus.st_data = 32'h7;
      step();
      bus.st_addr = 32'h204;
      step();
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1 || bus.st_ready !== 1'b0) $display("FAIL mid_pending got req=%b rdy=%b want 1/0", bus.mem_req, bus.st_ready); else pass_cnt++;
      reset = 1'b1;
      bus.mem_ack = 1'b1;
      step();
      reset = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) $display("FAIL mid_reset got req=%b empty=%b rdy=%b want 0/1/1", bus.mem_req, bus.empty, bus.st_ready); else pass_cnt++;
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.empty !== 1'b1 || bus.st_ready !== 1'b1) $display("FAIL mid_late_ack got empty=%b rdy=%b want 1/1", bus.empty, bus.st_ready); else pass_cnt++;
      // reset wins over a push presented in the same cycle
      reset = 1'b1;
      bus.st_valid = 1'b1; bus.st_addr = 32'h208;
      step();
      reset = 1'b0;
      bus.st_valid = 1'b0;
      #1;
      total_cnt++; if (bus.empty !== 1'b1) $display("FAIL rst_over_push got %b want 1", bus.empty); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_sb();
      test_sh_and_illegal();
      test_full();
      test_ld_conflict();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart of the M-stage load byte extractor.
- Takes sw/sh/sb requests from the M stage and produces a 4-bit byte-enable and lane-aligned write data. Misaligned or illegal requests are flagged and dropped.
- Legal stores queue in a small FIFO that drains to data memory over a req/ack handshake.
- Also flags loads whose word address matches a pending store, so hazard control can stall.

Parameters:
- DEPTH, 2, number of buffered stores. Power of two, 2..8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- st_valid  input  1  M stage presents a store this cycle
- st_op  input  2  00 sw, 01 sb, 10 sh, 11 illegal
- st_addr  input  32  byte address
- st_data  input  32  register rt value
- st_ready  output  1  buffer can accept a store; high when count < DEPTH
- st_misalign  output  1  combinational; request is misaligned or illegal
- mem_req  output  1  head entry valid
- mem_addr  output  32  head word address, bits [1:0] = 00
- mem_byteen  output  4  head byte enables; bit i enables byte lane i (bits 8i+7:8i)
- mem_wdata  output  32  head lane-aligned data
- mem_ack  input  1  memory accepts the head entry this cycle
- ld_check_valid  input  1  a load is in the M stage
- ld_check_addr  input  32  load byte address
- ld_conflict  output  1  combinational; a buffered store targets the load's word
- empty  output  1  count == 0

Behaviour:
- Encoding, combinational:
  - sw: byteen 1111, data = st_data.
  - sh: byteen 0011 if addr[1]=0, else 1100; data = {st_data[15:0], st_data[15:0]}.
  - sb: byteen = 0001 << addr[1:0]; data = st_data[7:0] replicated to all four lanes.
- st_misalign = st_valid and any of:
  - op = 11;
  - sw with addr[1:0] != 00;
  - sh with addr[0] = 1.
  - st_misalign is independent of st_ready.
- Push happens when st_valid and st_ready and not st_misalign. A flagged request is never written and has no side effect.
- Entry contents: {addr[31:2], byteen, aligned data}, written at the tail; tail pointer increments modulo DEPTH.
- Pop happens when mem_req and mem_ack. Head pointer increments modulo DEPTH. mem_ack while mem_req=0 is ignored.
- Head outputs (mem_addr, mem_byteen, mem_wdata) come straight from the head entry register. When empty they are 0.
- Latency: a store pushed in cycle N appears on mem_req in cycle N+1 at the earliest. There is no combinational bypass from st_* to mem_*.
- Drain order is strict FIFO. Stores are never merged or reordered.
- Simultaneous push and pop, 0 < count < DEPTH: both happen and count is unchanged.
- Full (count = DEPTH): st_ready = 0 even if mem_ack is high that cycle. A same-cycle pop does not free the slot for a push; st_ready rises the next cycle.
- Empty: mem_req = 0 and a push that cycle does not appear until the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits. count is a separate log2(DEPTH)+1-bit counter; full/empty decode from count only.
- ld_conflict = ld_check_valid and some valid entry e has e.addr[31:2] == ld_check_addr[31:2].
  - Only buffered entries are compared; a store being pushed in the same cycle is not.
  - Byte enables are ignored in the comparison (conservative).
  - An entry popped this cycle still counts this cycle.
- Reset:
  - count, head and tail are cleared, and all entry valid state is cleared.
  - mem_req = 0, empty = 1, st_ready = 1, ld_conflict = 0, mem_* = 0.
  - Pending stores are discarded, including one mid-handshake (mem_req high and mem_ack not yet seen).
  - Reset takes priority over a simultaneous push or pop.

Test Plan:
- After reset: st_valid=1, op=01 (sb), addr=0x0000_1003, data=0x0000_00A5.
  - Next cycle: mem_req=1, mem_addr=0x0000_1000, mem_byteen=1000, mem_wdata=0xA5A5_A5A5.
  - Then mem_ack=1 -> empty=1 the following cycle.
- sh to addr 0x2002 with data 0x1234_BEEF -> byteen 1100, wdata 0xBEEF_BEEF.
  - sh to 0x2001 -> st_misalign=1, no push, empty stays 1.
  - op=11 -> st_misalign=1, no push, empty stays 1.
- With DEPTH=2 and mem_ack=0: push sw 0x10 (data 0x1111_1111), then sw 0x14 (data 0x2222_2222).
  - st_ready=0 after the second push.
  - A third store with mem_ack=1 in the same cycle is not accepted; st_ready returns to 1 next cycle.
  - Drain order: 0x10, then 0x14.
- Entry holding 0x3000 buffered:
  - ld_check_valid=1, ld_check_addr=0x3002 -> ld_conflict=1.
  - ld_check_addr=0x3004 -> ld_conflict=0.
  - ld_check_valid=0 -> ld_conflict=0.
- Count held at 1, push and pop in the same cycle for 6 consecutive cycles (more than 2*DEPTH):
  - count stays 1;
  - FIFO order is preserved across pointer wrap;
  - no entry is lost or duplicated.
- Two entries pending, mem_req=1: assert reset for 1 cycle.
  - Next cycle: mem_req=0, empty=1, st_ready=1.
  - A later mem_ack does not pop anything.
